// File: rtl/ctrl_bin_sched.sv
// ctrl_bin_sched
//   Top-level bin scheduler. Walks bins 1..num_bins in order. Each bin is
//   loaded, solved by the core, and stored back. A partial SAT advances to
//   the next bin. A partial UNSAT either ends the solve or drives a global
//   backtrack to the bin named by conflict analysis.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start_i, num_bins_i      solve request and bin count (sampled in IDLE)
//   done_o, sat_o, unsat_o   verdict; holds until the next accepted start
//   err_o                    backtrack target was not below the current bin
//   cur_bin_id_o             bin being worked on
//   start_load_o/done_load_i     load handshake
//   start_core_o/done_core_i     core handshake; core_sat_i, core_unsat_i and
//                                bkt_bin_num_i are valid with done_core_i
//   start_store_o/done_store_i   store handshake
//   start_bkt_o/done_bkt_i       global backtrack handshake to bkt_bin_id_o
//   bin_loads_o              LOAD entries since the last start (saturating)
module ctrl_bin_sched #(
  parameter int WIDTH_BIN_ID = 10,
  parameter int WIDTH_CNT    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH_BIN_ID-1:0] num_bins_i,
  output logic                    done_o,
  output logic                    sat_o,
  output logic                    unsat_o,
  output logic                    err_o,
  output logic [WIDTH_BIN_ID-1:0] cur_bin_id_o,
  output logic                    start_load_o,
  input  logic                    done_load_i,
  output logic                    start_core_o,
  input  logic                    done_core_i,
  input  logic                    core_sat_i,
  input  logic                    core_unsat_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i,
  output logic                    start_store_o,
  input  logic                    done_store_i,
  output logic                    start_bkt_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_id_o,
  input  logic                    done_bkt_i,
  output logic [WIDTH_CNT-1:0]    bin_loads_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CORE, STORE, BKT, DONE_SAT, DONE_UNSAT
  } state_t;

  state_t                  state;
  logic [WIDTH_BIN_ID-1:0] num_bins_q;
  logic [WIDTH_BIN_ID-1:0] tgt_q;
  logic                    res_sat_q;

  function automatic logic [WIDTH_CNT-1:0] sat_inc(input logic [WIDTH_CNT-1:0] v);
    return (&v) ? v : v + {{(WIDTH_CNT-1){1'b0}}, 1'b1};
  endfunction

  localparam logic [WIDTH_BIN_ID-1:0] BIN_ONE = {{(WIDTH_BIN_ID-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_CNT-1:0]    CNT_ONE = {{(WIDTH_CNT-1){1'b0}}, 1'b1};

  // Solve parameters and the latched core outcome carry no control meaning
  // outside the states that write them, so they are left unreset.
  // Neither result flag set counts as unsat; sat wins if both are set.
  always_ff @(posedge clk) begin
    if (state == IDLE && start_i) num_bins_q <= num_bins_i;
    if (state == CORE && !start_core_o && done_core_i) begin
      res_sat_q <= core_sat_i;
      tgt_q     <= bkt_bin_num_i;
    end
  end

  // A pulse output being high marks the first cycle of a state visit; done
  // inputs are only honoured once it has dropped, which gives every
  // handshake state a minimum stay of two cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      done_o        <= 1'b0;
      sat_o         <= 1'b0;
      unsat_o       <= 1'b0;
      err_o         <= 1'b0;
      cur_bin_id_o  <= '0;
      start_load_o  <= 1'b0;
      start_core_o  <= 1'b0;
      start_store_o <= 1'b0;
      start_bkt_o   <= 1'b0;
      bkt_bin_id_o  <= '0;
      bin_loads_o   <= '0;
    end else begin
      start_load_o  <= 1'b0;
      start_core_o  <= 1'b0;
      start_store_o <= 1'b0;
      start_bkt_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            err_o   <= 1'b0;
            unsat_o <= 1'b0;
            if (num_bins_i == '0) begin
              state       <= DONE_SAT;
              done_o      <= 1'b1;
              sat_o       <= 1'b1;
              bin_loads_o <= '0;
            end else begin
              state        <= LOAD;
              done_o       <= 1'b0;
              sat_o        <= 1'b0;
              cur_bin_id_o <= BIN_ONE;
              start_load_o <= 1'b1;
              bin_loads_o  <= CNT_ONE;
            end
          end
        end
        LOAD: begin
          if (!start_load_o && done_load_i) begin
            state        <= CORE;
            start_core_o <= 1'b1;
          end
        end
        CORE: begin
          if (!start_core_o && done_core_i) begin
            state         <= STORE;
            start_store_o <= 1'b1;
          end
        end
        STORE: begin
          if (!start_store_o && done_store_i) begin
            if (res_sat_q) begin
              if (cur_bin_id_o == num_bins_q) begin
                state  <= DONE_SAT;
                done_o <= 1'b1;
                sat_o  <= 1'b1;
              end else begin
                state        <= LOAD;
                cur_bin_id_o <= cur_bin_id_o + BIN_ONE;
                start_load_o <= 1'b1;
                bin_loads_o  <= sat_inc(bin_loads_o);
              end
            end else if (tgt_q == '0) begin
              state   <= DONE_UNSAT;
              done_o  <= 1'b1;
              unsat_o <= 1'b1;
            end else if (tgt_q >= cur_bin_id_o) begin
              // Conflict analysis may only send us back to an earlier bin.
              state   <= DONE_UNSAT;
              done_o  <= 1'b1;
              unsat_o <= 1'b1;
              err_o   <= 1'b1;
            end else begin
              state        <= BKT;
              start_bkt_o  <= 1'b1;
              bkt_bin_id_o <= tgt_q;
            end
          end
        end
        BKT: begin
          if (!start_bkt_o && done_bkt_i) begin
            state        <= LOAD;
            cur_bin_id_o <= bkt_bin_id_o;
            start_load_o <= 1'b1;
            bin_loads_o  <= sat_inc(bin_loads_o);
          end
        end
        DONE_SAT, DONE_UNSAT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_bin_sched.sv
// Testbench for ctrl_bin_sched: table-driven solve scenarios, hand-written
// handshake/reset sequences, and randomized solves checked against a
// bin-walk reference model.
module tb_ctrl_bin_sched;
  localparam int BW = 10;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [BW-1:0] num_bins_i;
  logic          done_o, sat_o, unsat_o, err_o;
  logic [BW-1:0] cur_bin_id_o;
  logic          start_load_o, done_load_i;
  logic          start_core_o, done_core_i, core_sat_i, core_unsat_i;
  logic [BW-1:0] bkt_bin_num_i;
  logic          start_store_o, done_store_i;
  logic          start_bkt_o, done_bkt_i;
  logic [BW-1:0] bkt_bin_id_o;
  logic [CW-1:0] bin_loads_o;

  always #5 clk = ~clk;

  ctrl_bin_sched #(.WIDTH_BIN_ID(BW), .WIDTH_CNT(CW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_bins_i(num_bins_i),
    .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o), .err_o(err_o),
    .cur_bin_id_o(cur_bin_id_o),
    .start_load_o(start_load_o), .done_load_i(done_load_i),
    .start_core_o(start_core_o), .done_core_i(done_core_i),
    .core_sat_i(core_sat_i), .core_unsat_i(core_unsat_i),
    .bkt_bin_num_i(bkt_bin_num_i),
    .start_store_o(start_store_o), .done_store_i(done_store_i),
    .start_bkt_o(start_bkt_o), .bkt_bin_id_o(bkt_bin_id_o),
    .done_bkt_i(done_bkt_i), .bin_loads_o(bin_loads_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Core responses, one per core run: 0 sat, 1 unsat, 2 neither flag, 3 both flags.
  logic [1:0] rsp_kind [64];
  int         rsp_bkt  [64];

  int got_loads[$], got_bkts[$], exp_loads[$], exp_bkts[$];
  int n_stores;

  task automatic clear_rsp();
    for (int i = 0; i < 64; i++) begin
      rsp_kind[i] = 2'd0;
      rsp_bkt[i]  = int'($urandom_range(0, 7));
    end
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; done_load_i = 1'b0; done_core_i = 1'b0; done_store_i = 1'b0;
    done_bkt_i = 1'b0; core_sat_i = 1'b0; core_unsat_i = 1'b0; bkt_bin_num_i = '0;
  endtask

  // Reference: walk the bins using the scheduling rules directly.
  task automatic model(input int n, output bit s, output bit u, output bit e, output int st);
    int cur, k, t;
    bit ok;
    exp_loads.delete(); exp_bkts.delete();
    s = 0; u = 0; e = 0; st = 0;
    if (n == 0) begin s = 1; return; end
    cur = 1; k = 0;
    exp_loads.push_back(1);
    while (k < 64) begin
      ok = (rsp_kind[k] == 2'd0) || (rsp_kind[k] == 2'd3);
      t  = rsp_bkt[k];
      k++; st++;
      if (ok) begin
        if (cur == n) begin s = 1; return; end
        cur++;
        exp_loads.push_back(cur);
      end else if (t == 0) begin
        u = 1; return;
      end else if (t >= cur) begin
        u = 1; e = 1; return;
      end else begin
        exp_bkts.push_back(t);
        cur = t;
        exp_loads.push_back(cur);
      end
    end
  endtask

  function automatic int dly(input bit rnd);
    return rnd ? int'($urandom_range(1, 4)) : 1;
  endfunction

  // Starts a solve and plays the load/core/store/bkt units until done_o.
  // lat = rising edges after the start-accepting edge until done_o is high.
  task automatic run_solve(input int n, input bit rnd, output int lat, output bit tmo);
    int ld, cr, st, bk, k, cyc;
    got_loads.delete(); got_bkts.delete(); n_stores = 0;
    ld = 0; cr = 0; st = 0; bk = 0; k = 0; tmo = 0;
    @(negedge clk);
    start_i = 1'b1; num_bins_i = BW'(n);
    @(negedge clk);
    start_i = 1'b0; num_bins_i = BW'($urandom);
    cyc = 1;
    while (!done_o) begin
      done_load_i = 1'b0; done_core_i = 1'b0; done_store_i = 1'b0; done_bkt_i = 1'b0;
      core_sat_i = 1'b0; core_unsat_i = 1'b0; bkt_bin_num_i = BW'($urandom);
      if (ld > 0) begin ld--; if (ld == 0) done_load_i = 1'b1; end
      if (st > 0) begin st--; if (st == 0) done_store_i = 1'b1; end
      if (bk > 0) begin bk--; if (bk == 0) done_bkt_i = 1'b1; end
      if (cr > 0) begin
        cr--;
        if (cr == 0) begin
          done_core_i   = 1'b1;
          core_sat_i    = (rsp_kind[k] == 2'd0) || (rsp_kind[k] == 2'd3);
          core_unsat_i  = (rsp_kind[k] == 2'd1) || (rsp_kind[k] == 2'd3);
          bkt_bin_num_i = BW'(rsp_bkt[k]);
          if (k < 63) k++;
        end
      end
      if (start_load_o)  begin got_loads.push_back(int'(cur_bin_id_o)); ld = dly(rnd); end
      if (start_core_o)  cr = dly(rnd);
      if (start_store_o) begin n_stores++; st = dly(rnd); end
      if (start_bkt_o)   begin got_bkts.push_back(int'(bkt_bin_id_o)); bk = dly(rnd); end
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin tmo = 1; break; end
    end
    idle_inputs();
    lat = cyc - 1;
  endtask

  task automatic compare_seqs(input string tag);
    check({tag, "_load_count"}, got_loads.size(), exp_loads.size());
    for (int i = 0; i < got_loads.size() && i < exp_loads.size(); i++)
      check({tag, "_load_bin"}, got_loads[i], exp_loads[i]);
    check({tag, "_bkt_count"}, got_bkts.size(), exp_bkts.size());
    for (int i = 0; i < got_bkts.size() && i < exp_bkts.size(); i++)
      check({tag, "_bkt_bin"}, got_bkts[i], exp_bkts[i]);
  endtask

  task automatic recover(input bit tmo);
    if (tmo) begin
      check("timeout", 1, 0);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end
  endtask

  typedef struct packed {
    int       n;
    int       ui;
    logic [1:0] kd;
    int       bk;
    bit       s;
    bit       u;
    bit       e;
    int       ld;
    int       st;
    int       bt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat, mst;
    bit tmo, ms, mu, me;
    int n;

    //           n  ui kd bk   s  u  e  ld st bt
    tbl[0] = '{3, 0, 2'd0, 0, 1, 0, 0, 3, 3, 0};
    tbl[1] = '{3, 2, 2'd1, 1, 1, 0, 0, 6, 6, 1};
    tbl[2] = '{2, 1, 2'd1, 0, 0, 1, 0, 2, 2, 0};
    tbl[3] = '{4, 1, 2'd1, 3, 0, 1, 1, 2, 2, 0};
    tbl[4] = '{0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0};
    tbl[5] = '{3, 2, 2'd1, 3, 0, 1, 1, 3, 3, 0};
    tbl[6] = '{2, 0, 2'd3, 0, 1, 0, 0, 2, 2, 0};
    tbl[7] = '{2, 1, 2'd2, 0, 0, 1, 0, 2, 2, 0};
    tbl[8] = '{1, 0, 2'd2, 1, 0, 1, 1, 1, 1, 0};

    rst = 1'b1; num_bins_i = '0;
    idle_inputs();
    #1;
    check("reset_outputs",
          {done_o, sat_o, unsat_o, err_o, start_load_o, start_core_o, start_store_o,
           start_bkt_o, cur_bin_id_o, bkt_bin_id_o, bin_loads_o}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Table-driven scenarios, every unit answering one cycle after its pulse.
    for (int i = 0; i < 9; i++) begin
      clear_rsp();
      rsp_kind[tbl[i].ui] = tbl[i].kd;
      rsp_bkt[tbl[i].ui]  = tbl[i].bk;
      run_solve(tbl[i].n, 1'b0, lat, tmo);
      recover(tmo);
      check($sformatf("t%0d_done", i), done_o, 1);
      check($sformatf("t%0d_sat", i), sat_o, tbl[i].s);
      check($sformatf("t%0d_unsat", i), unsat_o, tbl[i].u);
      check($sformatf("t%0d_err", i), err_o, tbl[i].e);
      check($sformatf("t%0d_bin_loads", i), bin_loads_o, tbl[i].ld);
      check($sformatf("t%0d_stores", i), n_stores, tbl[i].st);
      check($sformatf("t%0d_bkts", i), got_bkts.size(), tbl[i].bt);
      if (tbl[i].bt > 0 && got_bkts.size() > 0)
        check($sformatf("t%0d_bkt_target", i), got_bkts[0], tbl[i].bk);
      if (i == 0) check("t0_latency", lat, 18);
      if (i == 4) check("t4_latency", lat, 0);
      model(tbl[i].n, ms, mu, me, mst);
      compare_seqs($sformatf("t%0d", i));
      @(negedge clk); @(negedge clk);
      check($sformatf("t%0d_done_hold", i), {done_o, sat_o, unsat_o, err_o},
            {1'b1, tbl[i].s, tbl[i].u, tbl[i].e});
    end

    // Done coincident with the load pulse must be ignored.
    @(negedge clk); start_i = 1'b1; num_bins_i = 10'd1;
    @(negedge clk); start_i = 1'b0;
    check("coinc_load_pulse", start_load_o, 1);
    done_load_i = 1'b1;
    @(negedge clk); done_load_i = 1'b0;
    check("coinc_no_core", start_core_o, 0);
    check("coinc_no_refire", start_load_o, 0);
    @(negedge clk); done_load_i = 1'b1;
    @(negedge clk); done_load_i = 1'b0;
    check("coinc_core_pulse", start_core_o, 1);
    @(negedge clk); done_core_i = 1'b1; core_sat_i = 1'b1;
    @(negedge clk); done_core_i = 1'b0; core_sat_i = 1'b0;
    check("coinc_store_pulse", start_store_o, 1);
    @(negedge clk); done_store_i = 1'b1;
    @(negedge clk); done_store_i = 1'b0;
    check("coinc_done_sat", {done_o, sat_o, unsat_o}, 3'b110);

    // Reset in CORE with a core done pending; a mid-solve start is ignored.
    @(negedge clk); start_i = 1'b1; num_bins_i = 10'd3;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); done_load_i = 1'b1;
    @(negedge clk); done_load_i = 1'b0;
    check("rst_seq_core_pulse", start_core_o, 1);
    start_i = 1'b1; num_bins_i = 10'd0;
    @(negedge clk); start_i = 1'b0;
    done_core_i = 1'b1; core_sat_i = 1'b1;
    check("midsolve_start_bin", cur_bin_id_o, 1);
    check("midsolve_start_loads", bin_loads_o, 1);
    check("midsolve_start_done", done_o, 0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {done_o, sat_o, unsat_o, err_o, start_load_o, start_core_o, start_store_o,
           start_bkt_o, cur_bin_id_o, bkt_bin_id_o, bin_loads_o}, 64'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    clear_rsp();
    run_solve(3, 1'b0, lat, tmo);
    recover(tmo);
    check("after_rst_first_bin", got_loads.size() > 0 ? got_loads[0] : -1, 1);
    check("after_rst_sat", {done_o, sat_o, unsat_o}, 3'b110);
    check("after_rst_loads", bin_loads_o, 3);

    // Randomized solves against the reference model.
    for (int r = 0; r < 40; r++) begin
      clear_rsp();
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      for (int j = 0; j < 10; j++) begin
        rsp_kind[j] = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
        rsp_bkt[j]  = int'($urandom_range(0, 7));
      end
      model(n, ms, mu, me, mst);
      run_solve(n, 1'b1, lat, tmo);
      recover(tmo);
      check($sformatf("r%0d_verdict", r), {done_o, sat_o, unsat_o, err_o}, {1'b1, ms, mu, me});
      check($sformatf("r%0d_bin_loads", r), bin_loads_o, exp_loads.size());
      check($sformatf("r%0d_stores", r), n_stores, mst);
      compare_seqs($sformatf("r%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
